// File: rtl/ebus_ctl_if.sv
// EBUS controller signal bundle: APR request side plus device bus side.
// The controller connects through 'master'; the APR/device model through 'slave'.
interface ebus_ctl_if;
   logic        ebusReq;
   logic        CONIorDATAI;
   logic [2:0]  func;
   logic [7:0]  dev;
   logic [35:0] wdata;
   logic [7:0]  EBUS_DS;
   logic        ebusDSStrobe;
   logic [2:0]  EBUS_F;
   logic        ebusDemand;
   logic        ebusXfer;
   logic [35:0] EBUS;
   logic        CTLdrivingEBUS;
   logic [35:0] CTL_EBUS;
   logic [35:0] rdata;
   logic        ebusReturn;
   logic        ebusTimeout;

   modport master (
      input  ebusReq, CONIorDATAI, func, dev, wdata, ebusXfer, EBUS,
      output EBUS_DS, ebusDSStrobe, EBUS_F, ebusDemand, CTLdrivingEBUS,
             CTL_EBUS, rdata, ebusReturn, ebusTimeout
   );

   modport slave (
      output ebusReq, CONIorDATAI, func, dev, wdata, ebusXfer, EBUS,
      input  EBUS_DS, ebusDSStrobe, EBUS_F, ebusDemand, CTLdrivingEBUS,
             CTL_EBUS, rdata, ebusReturn, ebusTimeout
   );
endinterface

// File: rtl/ebus_ctl.sv
// EBUS transfer sequencer: select/function setup, demand with bounded wait
// for the device acknowledge, release and a one-cycle return to the APR.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for ebusReq with the acknowledge line quiet
// ST_SETUP   | select, function (and output data) held for SETUP cycles
// ST_DEMAND  | demand asserted, waiting for acknowledge or timeout
// ST_RELEASE | bus released, waiting for the acknowledge to drop
// ST_RETURN  | one-cycle completion pulse to the APR
module ebus_ctl #(
   parameter int TIMEOUT = 255,
   parameter int SETUP   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   ebus_ctl_if.master bus
);

   localparam int CNT_MAX = (TIMEOUT > SETUP) ? TIMEOUT : SETUP;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP - 1);
   localparam logic [CNT_W-1:0] TO_LOAD    = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DEMAND,
      ST_RELEASE,
      ST_RETURN
   } state_t;

   state_t           state;
   logic             xfer_meta;
   logic             xs;
   logic             is_input;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       ds_q;
   logic [2:0]       f_q;
   logic             strobe_q;
   logic             demand_q;
   logic             drv_q;
   logic [35:0]      ctl_ebus_q;
   logic [35:0]      rdata_q;
   logic             return_q;
   logic             timeout_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         xfer_meta  <= 1'b0;
         xs         <= 1'b0;
         is_input   <= 1'b0;
         cnt        <= '0;
         ds_q       <= '0;
         f_q        <= '0;
         strobe_q   <= 1'b0;
         demand_q   <= 1'b0;
         drv_q      <= 1'b0;
         ctl_ebus_q <= '0;
         rdata_q    <= '0;
         return_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         xfer_meta <= bus.ebusXfer;
         xs        <= xfer_meta;
         case (state)
            ST_IDLE: begin
               // A still-asserted acknowledge from the last device blocks a new grant.
               if (bus.ebusReq && !xs) begin
                  state      <= ST_SETUP;
                  is_input   <= bus.CONIorDATAI;
                  ds_q       <= bus.dev;
                  f_q        <= bus.func;
                  strobe_q   <= 1'b1;
                  drv_q      <= !bus.CONIorDATAI;
                  ctl_ebus_q <= bus.CONIorDATAI ? '0 : bus.wdata;
                  timeout_q  <= 1'b0;
                  cnt        <= SETUP_LOAD;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  state    <= ST_DEMAND;
                  demand_q <= 1'b1;
                  cnt      <= TO_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DEMAND: begin
               // Acknowledge is tested first so it wins on the terminal-count cycle.
               if (xs || cnt == '0) begin
                  state      <= ST_RELEASE;
                  demand_q   <= 1'b0;
                  strobe_q   <= 1'b0;
                  drv_q      <= 1'b0;
                  ctl_ebus_q <= '0;
                  ds_q       <= '0;
                  f_q        <= '0;
                  cnt        <= TO_LOAD;
                  if (xs) begin
                     if (is_input) rdata_q <= bus.EBUS;
                  end else begin
                     timeout_q <= 1'b1;
                     rdata_q   <= '0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!xs || (timeout_q && cnt == '0)) begin
                  state    <= ST_RETURN;
                  return_q <= 1'b1;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RETURN: begin
               state    <= ST_IDLE;
               return_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.EBUS_DS        = ds_q;
   assign bus.EBUS_F         = f_q;
   assign bus.ebusDSStrobe   = strobe_q;
   assign bus.ebusDemand     = demand_q;
   assign bus.CTLdrivingEBUS = drv_q;
   assign bus.CTL_EBUS       = ctl_ebus_q;
   assign bus.rdata          = rdata_q;
   assign bus.ebusReturn     = return_q;
   assign bus.ebusTimeout    = timeout_q;

endmodule

// File: tb/tb_ebus_ctl.sv
// Directed bench for ebus_ctl: APR/device model driving the slave side,
// expected completions queued at request time and popped at ebusReturn.
module tb_ebus_ctl;
   localparam int TIMEOUT = 255;
   localparam int SETUP   = 2;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [36:0] sb[$];

   ebus_ctl_if bus();

   ebus_ctl #(.TIMEOUT(TIMEOUT), .SETUP(SETUP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " ctrl"}, {bus.EBUS_DS, bus.ebusDSStrobe, bus.EBUS_F, bus.ebusDemand,
                             bus.CTLdrivingEBUS, bus.ebusReturn, bus.ebusTimeout}, 64'd0);
      check({tag, " CTL_EBUS"}, bus.CTL_EBUS, 64'd0);
      check({tag, " rdata"}, bus.rdata, 64'd0);
   endtask

   // One complete transfer; device raises ebusXfer on demand sample xfer_at (-1: never).
   task automatic run_xfer(input string tag, input bit coni, input logic [2:0] f,
                           input logic [7:0] d, input logic [35:0] wd, input logic [35:0] bus_val,
                           input int xfer_at, input bit drop_early, input bit keep_req,
                           input logic [35:0] exp_rdata, input bit exp_to,
                           input int exp_demand, input int exp_grant);
      int demand_cyc = 0;
      int setup_cyc  = 0;
      int strobe_at  = 0;
      int viol       = 0;
      bit seen_ret   = 0;
      bit done       = 0;
      bit exp_drv;
      logic [36:0] e;
      bus.CONIorDATAI = coni;
      bus.func        = f;
      bus.dev         = d;
      bus.wdata       = wd;
      bus.EBUS        = bus_val;
      bus.ebusReq     = 1'b1;
      sb.push_back({exp_to, exp_rdata});
      for (int k = 1; k < 1200 && !done; k++) begin
         tick();
         if (seen_ret) begin
            check({tag, " return width"}, bus.ebusReturn, 64'd0);
            check({tag, " idle after return"}, bus.ebusDSStrobe, 64'd0);
            done = 1;
         end else begin
            if (bus.ebusDemand) begin
               demand_cyc++;
               if (demand_cyc == xfer_at) bus.ebusXfer = 1'b1;
            end else if (demand_cyc > 0) begin
               bus.ebusXfer = 1'b0;
            end
            if (bus.ebusDSStrobe && strobe_at == 0) strobe_at = k;
            if (bus.ebusDSStrobe && demand_cyc == 0) setup_cyc++;
            if (bus.ebusDSStrobe && drop_early) bus.ebusReq = 1'b0;
            exp_drv = bus.ebusDSStrobe && !coni;
            if (bus.CTLdrivingEBUS !== exp_drv) viol++;
            if (bus.CTL_EBUS !== (exp_drv ? wd : 36'd0)) viol++;
            if (bus.ebusDemand && !bus.ebusDSStrobe) viol++;
            if (bus.ebusDSStrobe && (bus.EBUS_DS !== d || bus.EBUS_F !== f)) viol++;
            if (bus.ebusReturn) begin
               seen_ret = 1;
               if (!keep_req) bus.ebusReq = 1'b0;
               check({tag, " sb depth"}, sb.size(), 64'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check({tag, " rdata"}, bus.rdata, e[35:0]);
                  check({tag, " ebusTimeout"}, bus.ebusTimeout, e[36]);
               end
            end
         end
      end
      check({tag, " return seen"}, seen_ret, 64'd1);
      check({tag, " grant latency"}, strobe_at, exp_grant);
      check({tag, " setup cycles"}, setup_cyc, SETUP);
      check({tag, " demand cycles"}, demand_cyc, exp_demand);
      check({tag, " drive violations"}, viol, 64'd0);
   endtask

   initial begin
      int  n;
      bit  flag;
      reset_n          = 1'b0;
      bus.ebusReq      = 1'b0;
      bus.CONIorDATAI  = 1'b0;
      bus.func         = '0;
      bus.dev          = '0;
      bus.wdata        = '0;
      bus.ebusXfer     = 1'b0;
      bus.EBUS         = '0;
      repeat (2) tick();
      check_quiet("reset");
      reset_n = 1'b1;
      tick();

      run_xfer("coni", 1'b1, 3'b000, 8'h04, 36'd0, 36'o123456701234, 3, 1'b0, 1'b0,
               36'o123456701234, 1'b0, 5, 1);
      run_xfer("cono", 1'b0, 3'b001, 8'h10, 36'o777000000001, 36'o0, 2, 1'b1, 1'b0,
               36'o123456701234, 1'b0, 4, 1);
      run_xfer("timeout", 1'b1, 3'b000, 8'h20, 36'd0, 36'o555, -1, 1'b0, 1'b0,
               36'd0, 1'b1, TIMEOUT, 1);
      run_xfer("xfer on tc", 1'b1, 3'b010, 8'h21, 36'd0, 36'o246135702461, TIMEOUT - 2,
               1'b0, 1'b0, 36'o246135702461, 1'b0, TIMEOUT, 1);
      run_xfer("xfer after tc", 1'b1, 3'b010, 8'h22, 36'd0, 36'o314, TIMEOUT - 1,
               1'b0, 1'b0, 36'd0, 1'b1, TIMEOUT, 1);

      run_xfer("b2b first", 1'b1, 3'b011, 8'h30, 36'd0, 36'o111, 1, 1'b0, 1'b1,
               36'o111, 1'b0, 3, 1);
      run_xfer("b2b second", 1'b1, 3'b100, 8'h31, 36'd0, 36'o222, 1, 1'b0, 1'b0,
               36'o222, 1'b0, 3, 1);

      bus.CONIorDATAI = 1'b1;
      bus.dev         = 8'h40;
      bus.func        = 3'b101;
      bus.EBUS        = 36'o333;
      bus.ebusReq     = 1'b1;
      flag = 0;
      for (int k = 0; k < 20 && !flag; k++) begin
         tick();
         flag = bus.ebusDemand;
      end
      check("reset test demand reached", flag, 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_quiet("async reset");
      bus.ebusReq = 1'b0;
      flag = 0;
      repeat (3) begin
         tick();
         flag |= bus.ebusReturn;
      end
      reset_n = 1'b1;
      repeat (3) begin
         tick();
         flag |= bus.ebusReturn;
      end
      check("no return after abort", flag, 64'd0);
      run_xfer("post reset", 1'b1, 3'b000, 8'h41, 36'd0, 36'o707, 2, 1'b0, 1'b0,
               36'o707, 1'b0, 4, 1);

      bus.CONIorDATAI = 1'b1;
      bus.dev         = 8'h50;
      bus.func        = 3'b110;
      bus.ebusXfer    = 1'b1;
      repeat (4) tick();
      bus.ebusReq = 1'b1;
      flag = 0;
      n = 0;
      repeat (8) begin
         tick();
         flag |= bus.ebusDSStrobe;
         n++;
      end
      check("stuck xfer no grant", flag, 64'd0);
      bus.ebusXfer = 1'b0;
      run_xfer("after stuck", 1'b1, 3'b110, 8'h50, 36'd0, 36'o4321, 1, 1'b0, 1'b0,
               36'o4321, 1'b0, 3, 3);

      check("scoreboard drained", sb.size(), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
